// File: rtl/ps2_key_source.sv
// ---------------------------------------------------------------------------
// ps2_key_source
//
// Receives scancodes from the single PS/2 keyboard shared by both players and
// turns them into the two held-key slots read by the game-control FSM. The
// slots carry USB-HID usage codes, so the FSM's space-to-start check and the
// per-player move logic see the same values the USB keyboard path produced.
//
// Pipeline:
//   ps2_clk/ps2_data -> synchronisers -> falling-edge detect -> 11-bit frame
//   deserialiser (start, 8 data LSB first, odd parity, stop) -> set-2
//   make/break decoder -> per-player slot update.
//
// Ports:
//   Clk         system clock
//   Reset       synchronous, active-high reset
//   ps2_clk     raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data    raw PS/2 data from the keyboard (asynchronous)
//   keycode     player-1 held key (W/A/S/D/space) as HID code, 0x00 if none
//   keycode2    player-2 held key (arrows/Enter) as HID code, 0x00 if none
//   byte_valid  one-cycle pulse for every frame that passes parity and stop
//   byte_data   last good byte, valid while byte_valid is high
//   frame_err   one-cycle pulse on bad start/stop, bad parity or timeout
//
// Parameters:
//   TIMEOUT_CYCLES  Clk cycles without a PS/2 falling edge before a partial
//                   frame is dropped
//   SYNC_STAGES     synchroniser depth on both PS/2 inputs (2 or more)
// ---------------------------------------------------------------------------
module ps2_key_source #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] keycode2,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Set-2 prefix and keyboard housekeeping bytes.
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_BAT_OK   = 8'hAA;
  localparam logic [7:0] SC_ACK      = 8'hFA;
  localparam logic [7:0] SC_RESEND   = 8'hFE;
  localparam logic [7:0] SC_ECHO     = 8'hEE;

  typedef enum logic [1:0] {
    DEC_IDLE,     // waiting for a new scancode sequence
    DEC_EXT,      // E0 seen
    DEC_BRK,      // F0 seen
    DEC_EXT_BRK   // E0 F0 seen
  } dec_state_e;

  // -------------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   ps2_fall;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign ps2_fall   = clk_prev_q & ~ps2_clk_s;

  // Synchronisers reset to the bus idle level (high) so leaving reset can
  // never look like a falling edge; a frame already in flight when Reset
  // drops is only picked up from its next start bit.
  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // flops update together from the values present before the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  // -------------------------------------------------------------------------
  // Frame deserialiser with inactivity timeout
  //
  // bit_cnt_q counts received bits: 0 = waiting for start, 1..8 = data,
  // 9 = parity, 10 = stop. Data and parity shift in from the top, so after
  // the parity bit shift_q[7:0] holds the byte and shift_q[8] the parity.
  // -------------------------------------------------------------------------
  logic [3:0]      bit_cnt_q,    bit_cnt_d;
  logic [8:0]      shift_q,      shift_d;
  logic [TO_W-1:0] to_cnt_q,     to_cnt_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q,  byte_data_d;
  logic            frame_err_q,  frame_err_d;

  // NOTE: every signal driven here gets a default at the top of the block,
  // so no path through the branches can leave it unassigned (no latches).
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;

    if (ps2_fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == 4'd0) begin
        // A high start bit is line noise or a lost frame: reject it now.
        if (ps2_data_s) frame_err_d = 1'b1;
        else            bit_cnt_d   = 4'd1;
      end else if (bit_cnt_q < 4'd10) begin
        shift_d   = {ps2_data_s, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        // Stop bit: data plus parity must hold an odd number of ones.
        bit_cnt_d = 4'd0;
        if ((^shift_q) && ps2_data_s) begin
          byte_valid_d = 1'b1;
          byte_data_d  = shift_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d    = '0;
        bit_cnt_d   = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Scancode translation (0x00 = not a game key)
  // -------------------------------------------------------------------------
  function automatic logic [7:0] p1_hid(input logic [7:0] sc);
    case (sc)
      8'h1D:   return 8'h1A;  // W
      8'h1C:   return 8'h04;  // A
      8'h1B:   return 8'h16;  // S
      8'h23:   return 8'h07;  // D
      8'h29:   return 8'h2C;  // space
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] p2_hid(input logic [7:0] sc, input logic ext);
    if (ext) begin
      case (sc)
        8'h75:   return 8'h52;  // up
        8'h72:   return 8'h51;  // down
        8'h6B:   return 8'h50;  // left
        8'h74:   return 8'h4F;  // right
        default: return 8'h00;  // includes keypad Enter (E0 5A)
      endcase
    end
    return (sc == 8'h5A) ? 8'h28 : 8'h00;  // main Enter
  endfunction

  // -------------------------------------------------------------------------
  // Decoder: classify the incoming byte as a make or break event
  // -------------------------------------------------------------------------
  dec_state_e dec_q;
  logic       ev_make;
  logic       ev_break;
  logic       ev_ext;
  logic [7:0] p1_code;
  logic [7:0] p2_code;
  logic [7:0] keycode_q;
  logic [7:0] keycode2_q;

  always_comb begin
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (byte_valid_q) begin
      case (dec_q)
        DEC_IDLE: begin
          ev_make = (byte_data_q != SC_EXT)    && (byte_data_q != SC_BRK)  &&
                    (byte_data_q != SC_BAT_OK) && (byte_data_q != SC_ACK)  &&
                    (byte_data_q != SC_RESEND) && (byte_data_q != SC_ECHO);
        end
        DEC_EXT: begin
          ev_make = (byte_data_q != SC_EXT) && (byte_data_q != SC_BRK);
          ev_ext  = 1'b1;
        end
        DEC_BRK: begin
          ev_break = 1'b1;
        end
        default: begin  // DEC_EXT_BRK
          ev_break = 1'b1;
          ev_ext   = 1'b1;
        end
      endcase
    end
  end

  // Player-1 keys only exist without the E0 prefix.
  assign p1_code = ev_ext ? 8'h00 : p1_hid(byte_data_q);
  assign p2_code = p2_hid(byte_data_q, ev_ext);

  // Decoder FSM and slot registers. A frame error (including timeout) drops
  // any half-seen prefix so the next byte is read as a fresh sequence.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dec_q      <= DEC_IDLE;
      keycode_q  <= 8'h00;
      keycode2_q <= 8'h00;
    end else begin
      if (frame_err_q) begin
        dec_q <= DEC_IDLE;
      end else if (byte_valid_q) begin
        case (dec_q)
          DEC_IDLE: begin
            if      (byte_data_q == SC_EXT) dec_q <= DEC_EXT;
            else if (byte_data_q == SC_BRK) dec_q <= DEC_BRK;
          end
          DEC_EXT: begin
            if      (byte_data_q == SC_BRK) dec_q <= DEC_EXT_BRK;
            else if (byte_data_q != SC_EXT) dec_q <= DEC_IDLE;
          end
          default: dec_q <= DEC_IDLE;
        endcase
      end

      // Make: last pressed key wins its player's slot.
      if (ev_make) begin
        if (p1_code != 8'h00) keycode_q  <= p1_code;
        if (p2_code != 8'h00) keycode2_q <= p2_code;
      end

      // Break: only release the slot if it still holds this key, so letting
      // go of an older key does not cancel a newer one still held.
      if (ev_break) begin
        if ((p1_code != 8'h00) && (keycode_q  == p1_code)) keycode_q  <= 8'h00;
        if ((p2_code != 8'h00) && (keycode2_q == p2_code)) keycode2_q <= 8'h00;
      end
    end
  end

  assign keycode    = keycode_q;
  assign keycode2   = keycode2_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_source.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_source
//
// Directed bench for ps2_key_source. PS/2 frames are bit-banged on
// ps2_clk/ps2_data; every good byte sent is pushed to a scoreboard queue and
// popped by a monitor when byte_valid pulses. Slot values are compared with
// the HID codes each key sequence should leave behind.
// ---------------------------------------------------------------------------
module tb_ps2_key_source;

  localparam int TO = 1000;  // shortened timeout keeps the run brief
  localparam int H  = 4;     // Clk cycles per PS/2 clock half-period

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic [7:0] keycode2;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_key_source #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .keycode2  (keycode2),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         bv_seen    = 0;
  int         err_seen   = 0;
  int         exp_bv     = 0;
  int         exp_err    = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // Monitor: sampled on the falling Clk edge, away from DUT updates.
  always @(negedge Clk) begin
    if (byte_valid === 1'b1) begin
      bv_seen++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_byte_valid: observed byte 0x%0h expected none",
               byte_data);
      end else begin
        check("byte_data", {24'h0, byte_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (frame_err === 1'b1) err_seen++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // One PS/2 bit: data set while the clock is high, then a clock low pulse.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge Clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (12) @(negedge Clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    exp_bv++;
    send_frame(d, ~^d, 1'b1);
  endtask

  // Parity bit inverted relative to odd parity.
  task automatic send_bad_par(input logic [7:0] d);
    exp_err++;
    send_frame(d, ^d, 1'b1);
  endtask

  logic       got_bv;
  logic [7:0] kc_at_bv;
  logic [7:0] kc_next;
  logic [7:0] b29;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge Clk);
    check("rst_keycode",    {24'h0, keycode},    32'h00);
    check("rst_keycode2",   {24'h0, keycode2},   32'h00);
    check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    check("rst_frame_err",  {31'h0, frame_err},  32'h0);
    check("rst_byte_data",  {24'h0, byte_data},  32'h00);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);

    // ---------------- space: byte_valid then keycode next cycle ----------
    b29 = 8'h29;
    exp_q.push_back(b29);
    exp_bv++;
    got_bv = 1'b0;
    kc_at_bv = 8'hFF;
    kc_next = 8'hFF;
    fork
      send_frame(b29, ~^b29, 1'b1);
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge Clk);
          if (byte_valid === 1'b1) begin
            got_bv = 1'b1;
            kc_at_bv = keycode;
            @(negedge Clk);
            kc_next = keycode;
            break;
          end
        end
      end
    join
    check("space_bv_seen",      {31'h0, got_bv},   32'h1);
    check("space_kc_at_bv",     {24'h0, kc_at_bv}, 32'h00);
    check("space_kc_next",      {24'h0, kc_next},  32'h2C);
    check("space_bv_once",      bv_seen,           exp_bv);

    // ---------------- P1 last-pressed-wins and selective break ----------
    send_good(8'h1C);
    check("a_make",     {24'h0, keycode},  32'h04);
    send_good(8'h1D);
    check("w_make",     {24'h0, keycode},  32'h1A);
    send_good(8'hF0);
    send_good(8'h1C);
    check("a_break_ignored", {24'h0, keycode}, 32'h1A);
    send_good(8'hF0);
    send_good(8'h1D);
    check("w_break",    {24'h0, keycode},  32'h00);
    check("p1_kc2_idle", {24'h0, keycode2}, 32'h00);

    // ---------------- P2 extended keys, slots independent ----------------
    send_good(8'hE0);
    send_good(8'h75);
    check("up_make",    {24'h0, keycode2}, 32'h52);
    send_good(8'h1B);
    check("s_make",     {24'h0, keycode},  32'h16);
    check("s_kc2_kept", {24'h0, keycode2}, 32'h52);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    check("up_break",   {24'h0, keycode2}, 32'h00);
    check("up_kc_kept", {24'h0, keycode},  32'h16);

    // ---------------- parity errors reset the decoder ----------------
    send_bad_par(8'h23);
    check("badpar_err",     err_seen,          exp_err);
    check("badpar_kc_kept", {24'h0, keycode},  32'h16);
    send_good(8'hF0);
    send_bad_par(8'h23);
    send_good(8'h23);
    check("d_make_after_err", {24'h0, keycode}, 32'h07);
    check("badpar_bv_count",  bv_seen,          exp_bv);

    // ---------------- bad stop bit and high start bit ----------------
    exp_err++;
    send_frame(8'h1B, ~^8'h1B, 1'b0);
    check("badstop_err",     err_seen,         exp_err);
    check("badstop_kc_kept", {24'h0, keycode}, 32'h07);
    exp_err++;
    ps2_bit(1'b1);
    repeat (12) @(negedge Clk);
    check("badstart_err",    err_seen,         exp_err);

    // ---------------- timeout on a partial frame ----------------
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO / 2) @(negedge Clk);
    check("timeout_not_early", err_seen, exp_err);
    exp_err++;
    repeat (TO / 2 + 50) @(negedge Clk);
    check("timeout_err_once", err_seen, exp_err);
    repeat (TO + 50) @(negedge Clk);
    check("timeout_no_repeat", err_seen, exp_err);
    send_good(8'h5A);
    check("enter_make", {24'h0, keycode2}, 32'h28);

    // ---------------- reset mid-frame ----------------
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (TO + 50) @(negedge Clk);
    check("midrst_kc",      {24'h0, keycode},  32'h00);
    check("midrst_kc2",     {24'h0, keycode2}, 32'h00);
    check("midrst_no_bv",   bv_seen,           exp_bv);
    check("midrst_no_err",  err_seen,          exp_err);
    send_good(8'h6B);
    check("left_noext_unmapped", {24'h0, keycode2}, 32'h00);
    send_good(8'hE0);
    send_good(8'h6B);
    check("left_make",      {24'h0, keycode2}, 32'h50);

    // ---------------- final scoreboard ----------------
    repeat (10) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_bv_count",     bv_seen,      exp_bv);
    check("final_err_count",    err_seen,     exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
